// File: rtl/sysref_gen.sv
// SYSREF pulse-train generator: periodic or burst SYSREF with graceful stop and drain.
// Optional SYSREF_GEN_ALIGN_EN adds align_in, which gates the first pulse on a synchronised rising edge.
module sysref_gen #(
    parameter int CNT_W = 16
) (
    input  logic             master_clock,
    input  logic             master_resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] burst_count,
`ifdef SYSREF_GEN_ALIGN_EN
    input  logic             align_in,
`endif
    output logic             sysref_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] per_q, high_q, burst_q;
    logic [CNT_W-1:0] phase, phase_nxt, phase_inc, idx_nxt;
    logic [CNT_W-1:0] san_period, san_high;
    logic             sysref_nxt, done_nxt, latch;
    logic             end_of_period, last_pulse, arm_go;

`ifdef SYSREF_GEN_ALIGN_EN
    logic align_s1, align_s2, align_d;

    always_ff @(posedge master_clock or negedge master_resetn) begin
        if (!master_resetn) begin
            align_s1 <= 1'b0;
            align_s2 <= 1'b0;
            align_d  <= 1'b0;
        end else begin
            align_s1 <= align_in;
            align_s2 <= align_s1;
            align_d  <= align_s2;
        end
    end

    assign arm_go = align_s2 & ~align_d;
`else
    assign arm_go = 1'b1;
`endif

    // Clamp the requested timing so every period has at least one high and one low cycle.
    always_comb begin
        san_period = (period < CNT_W'(2)) ? CNT_W'(2) : period;
        san_high   = high_cycles;
        if (high_cycles == '0)
            san_high = CNT_W'(1);
        else if (high_cycles >= san_period)
            san_high = san_period - CNT_W'(1);
    end

    assign end_of_period = (phase == per_q - CNT_W'(1));
    assign last_pulse    = (burst_q != '0) && (pulse_idx == burst_q - CNT_W'(1));
    assign phase_inc     = end_of_period ? '0 : phase + CNT_W'(1);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        idx_nxt    = pulse_idx;
        sysref_nxt = 1'b0;
        done_nxt   = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    latch     = 1'b1;
                    idx_nxt   = '0;
                    phase_nxt = '0;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (arm_go) begin
                    state_nxt  = RUN;
                    phase_nxt  = '0;
                    sysref_nxt = 1'b1;
                end
            end
            RUN, DRAIN: begin
                phase_nxt  = phase_inc;
                sysref_nxt = (phase_inc < high_q);
                if (end_of_period)
                    idx_nxt = pulse_idx + CNT_W'(1);
                // A stop landing on the final cycle of a period ends the sequence right there.
                if (end_of_period && (state == DRAIN || last_pulse || stop)) begin
                    state_nxt  = IDLE;
                    done_nxt   = 1'b1;
                    sysref_nxt = 1'b0;
                end else if (state == RUN && stop) begin
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge master_clock or negedge master_resetn) begin
        if (!master_resetn) begin
            state      <= IDLE;
            phase      <= '0;
            per_q      <= '0;
            high_q     <= '0;
            burst_q    <= '0;
            sysref_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pulse_idx  <= '0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            sysref_out <= sysref_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            pulse_idx  <= idx_nxt;
            if (latch) begin
                per_q   <= san_period;
                high_q  <= san_high;
                burst_q <= burst_count;
            end
        end
    end

endmodule

// File: tb/tb_sysref_gen.sv
// Scoreboard bench for sysref_gen: each queued vector carries the inputs for one cycle and
// the {sysref_out, busy, done, pulse_idx} expected after the following rising edge.
module tb_sysref_gen;

    logic        master_clock = 1'b0;
    logic        master_resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] high_cycles = '0;
    logic [15:0] burst_count = '0;
    logic        sysref_out, busy, done;
    logic [15:0] pulse_idx;
`ifdef SYSREF_GEN_ALIGN_EN
    logic        align_in = 1'b0;
`endif

    sysref_gen #(.CNT_W(16)) dut (
        .master_clock (master_clock),
        .master_resetn(master_resetn),
        .start        (start),
        .stop         (stop),
        .period       (period),
        .high_cycles  (high_cycles),
        .burst_count  (burst_count),
`ifdef SYSREF_GEN_ALIGN_EN
        .align_in     (align_in),
`endif
        .sysref_out   (sysref_out),
        .busy         (busy),
        .done         (done),
        .pulse_idx    (pulse_idx)
    );

    always #5 master_clock = ~master_clock;

    typedef struct {
        logic        start;
        logic        stop;
        logic [15:0] p, h, b;
        logic [18:0] exp;   // {sysref_out, busy, done, pulse_idx}
    } vec_t;

    vec_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   idle_idx = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] pack(input logic s, input logic b, input logic d, input int idx);
        return {s, b, d, 16'(idx)};
    endfunction

    // Queue one full sequence. sp/sx: pulse and phase during which stop is raised (sp<0: none).
    // bsp: pulse whose first cycle carries a stray start with random config (bsp<0: none).
    task automatic gen_seq(input int p, input int h, input int b, input int sp, input int sx,
                           input int bsp);
        vec_t v;
        int   ep, eh, n;
        logic stop_next;
        ep = (p < 2) ? 2 : p;
        eh = (h == 0) ? 1 : ((h >= ep) ? ep - 1 : h);
        if (b == 0)                  n = sp + 1;
        else if (sp >= 0 && sp < b)  n = sp + 1;
        else                         n = b;
        v.start = 1'b1; v.stop = 1'b0;
        v.p = 16'(p); v.h = 16'(h); v.b = 16'(b);
        v.exp = pack(1'b0, 1'b1, 1'b0, 0);
        q.push_back(v);
        stop_next = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int ph = 0; ph < ep; ph++) begin
                v.start = (k == bsp && ph == 0);
                v.stop  = stop_next;
                v.p = 16'($urandom); v.h = 16'($urandom); v.b = 16'($urandom);
                v.exp = pack(ph < eh, 1'b1, 1'b0, k);
                q.push_back(v);
                stop_next = (k == sp && ph == sx);
            end
        end
        v.start = 1'b0; v.stop = stop_next;
        v.exp = pack(1'b0, 1'b0, 1'b1, n);
        q.push_back(v);
        v.stop = 1'b0;
        v.exp = pack(1'b0, 1'b0, 1'b0, n);
        q.push_back(v);
        idle_idx = n;
    endtask

    task automatic apply_n(input int cnt);
        vec_t v;
        for (int i = 0; i < cnt && q.size() > 0; i++) begin
            v = q.pop_front();
            start       = v.start;
            stop        = v.stop;
            period      = v.p;
            high_cycles = v.h;
            burst_count = v.b;
            @(posedge master_clock);
            #1;
            check("cycle", {13'd0, sysref_out, busy, done, pulse_idx}, {13'd0, v.exp});
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic apply_all();
        apply_n(q.size());
    endtask

    initial begin
        vec_t v;
        repeat (2) @(posedge master_clock);
        #1;
        check("reset_state", {13'd0, sysref_out, busy, done, pulse_idx}, 32'd0);
        @(negedge master_clock);
        master_resetn = 1'b1;

        // Nominal burst of three 8-cycle periods, 2 high.
        gen_seq(8, 2, 3, -1, 0, -1);
        apply_all();
        check("burst3_idx", {16'd0, pulse_idx}, 32'd3);

        // Degenerate config sanitised to period 2, high 1.
        gen_seq(1, 0, 4, -1, 0, -1);
        apply_all();

        // Continuous run, stop in high phase of pulse 5, with a stray start mid-run.
        gen_seq(10, 4, 0, 4, 1, 2);
        apply_all();
        check("drain_idx", {16'd0, pulse_idx}, 32'd5);

        // Start and stop together in IDLE: nothing happens and pulse_idx holds.
        v.start = 1'b1; v.stop = 1'b1; v.p = 16'd4; v.h = 16'd1; v.b = 16'd1;
        v.exp = pack(1'b0, 1'b0, 1'b0, idle_idx);
        q.push_back(v);
        v.start = 1'b0; v.stop = 1'b1;
        q.push_back(v);
        v.stop = 1'b0;
        q.push_back(v);
        apply_all();

        // Stop while in ARM: done, no pulse.
        v.start = 1'b1; v.stop = 1'b0; v.p = 16'd6; v.h = 16'd2; v.b = 16'd0;
        v.exp = pack(1'b0, 1'b1, 1'b0, 0);
        q.push_back(v);
        v.start = 1'b0; v.stop = 1'b1;
        v.exp = pack(1'b0, 1'b0, 1'b1, 0);
        q.push_back(v);
        v.stop = 1'b0;
        v.exp = pack(1'b0, 1'b0, 1'b0, 0);
        q.push_back(v);
        apply_all();

        // High >= period clamps to period-1.
        gen_seq(5, 9, 2, -1, 0, -1);
        apply_all();

        // Stop on the very last cycle of the final burst period: single normal done.
        gen_seq(4, 1, 2, 1, 3, -1);
        apply_all();

        // Stop on the last cycle of a non-final period in continuous mode.
        gen_seq(3, 1, 0, 1, 2, -1);
        apply_all();

        // Reset mid-high-phase, then a fresh sequence right after release.
        gen_seq(10, 4, 0, 5, 0, -1);
        apply_n(13);
        q.delete();
        #2;
        master_resetn = 1'b0;
        #1;
        check("async_rst", {13'd0, sysref_out, busy, done, pulse_idx}, 32'd0);
        @(negedge master_clock);
        #1;
        check("rst_hold", {13'd0, sysref_out, busy, done, pulse_idx}, 32'd0);
        master_resetn = 1'b1;
        gen_seq(6, 3, 2, -1, 0, -1);
        apply_all();
        check("post_rst_idx", {16'd0, pulse_idx}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysref_gen.md
SYSREF_GEN -- requirements
Module: sysref_gen

Interface
- REQ-001: Parameter CNT_W, default 16, width of period/high/burst-count fields.
- REQ-002: master_clock  input  1  sole clock; all state on rising edge.
- REQ-003: master_resetn  input  1  asynchronous, active-low reset.
- REQ-004: start  input  1  single-cycle request to begin a SYSREF sequence.
- REQ-005: stop  input  1  single-cycle request to end a running sequence.
- REQ-006: period  input  CNT_W  SYSREF period in master_clock cycles, latched at start.
- REQ-007: high_cycles  input  CNT_W  pulse high time in cycles, latched at start.
- REQ-008: burst_count  input  CNT_W  number of pulses, latched at start; 0 = continuous.
- REQ-009: sysref_out  output  1  registered SYSREF to the ADC/DAC user SYSREF inputs.
- REQ-010: busy  output  1  high in ARM, RUN or DRAIN.
- REQ-011: done  output  1  one-cycle pulse when a sequence ends.
- REQ-012: pulse_idx  output  CNT_W  pulses completed in the current sequence; wraps modulo 2^CNT_W.

Function
- REQ-013: States are IDLE, ARM, RUN and DRAIN.
- REQ-014: IDLE with start=1 and stop=0 latches the configuration and goes to ARM; start with stop in IDLE is ignored.
- REQ-015: Configuration is sanitised at latch: period<2 becomes 2; high_cycles=0 becomes 1; high_cycles>=period becomes period-1.
- REQ-016: Without the alignment feature, ARM lasts exactly one cycle and then enters RUN.
- REQ-017: sysref_out goes high on the edge that enters RUN, i.e. 2 cycles after start is sampled.
- REQ-018: In RUN, each pulse is high for high_cycles and low for period-high_cycles; pulses repeat back-to-back with no gap cycle.
- REQ-019: pulse_idx increments on the last low cycle of each period and clears to 0 at latch.
- REQ-020: With burst_count=N>0, the block completes N full periods, then enters IDLE and asserts done for 1 cycle.
- REQ-021: stop sampled in RUN moves to DRAIN.
- REQ-022: In DRAIN, the current period completes, including its low phase, then the block enters IDLE with done; the output is never truncated mid-pulse.
- REQ-023: stop in ARM returns to IDLE with done and no pulse emitted.
- REQ-024: start while busy is ignored; configuration input changes while busy have no effect.
- REQ-025: stop in IDLE is ignored with no done.
- REQ-026: If stop arrives on the last cycle of the final burst period, the sequence ends normally with a single done.
- REQ-027: sysref_out, busy, done and pulse_idx are all flop outputs with no combinational path from inputs.

Reset
- REQ-028: master_resetn low asynchronously forces IDLE, sysref_out=0, busy=0, done=0, pulse_idx=0 and clears latched configuration and counters.
- REQ-029: Reset mid-pulse drops sysref_out immediately with no done.
- REQ-030: Release is synchronous to master_clock; start is honoured from the first edge after release.

Configuration
- REQ-031: Macro SYSREF_GEN_ALIGN_EN adds input align_in (1 bit, asynchronous) with a 2-flop synchroniser.
- REQ-032: With the macro defined, ARM waits for a rising edge of the synchronised align_in and enters RUN on the following edge.
- REQ-033: With the macro defined, stop in ARM aborts per REQ-023.
- REQ-034: Without the macro, the align_in port is absent and ARM behaves per REQ-016.

Verification
- REQ-035: Set period=8, high=2, burst=3, pulse start -> sysref_out high 2, low 6, repeated 3 times starting 2 cycles after start; done 1 cycle after the 3rd low phase; pulse_idx=3.
- REQ-036: Set period=1, high=0 -> sanitised to period 2, high 1; alternating 1/0 output.
- REQ-037: Set period=10, high=4, burst=0, stop during high phase of pulse 5 -> pulse completes its full 4 high and 6 low cycles; done; pulse_idx=5.
- REQ-038: Start and stop in the same cycle in IDLE -> no activity, busy=0. Start while busy -> no change.
- REQ-039: Assert master_resetn low mid-high-phase -> sysref_out=0 immediately, all outputs reset; a new start afterwards runs normally.
- REQ-040: With SYSREF_GEN_ALIGN_EN defined, start then align_in rising 10 cycles later -> first pulse 3 cycles after the align edge (2 sync + 1); stop before align -> done, no pulse.
